// File: rtl/arith_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arith_pkg : shared types, widths and helpers for the arithmetic unit |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package arith_pkg;

    localparam int DIV_M = 8;
    localparam int DIV_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_restore_step : one restoring-division iteration (combinational)  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module div_restore_step #(
    parameter int N = 8
) (
    input  logic [N:0]   p,
    input  logic         din,
    input  logic [N-1:0] bq,
    output logic [N:0]   p_next,
    output logic         qbit
);

    logic [N:0] w_pt;
    logic [N:0] w_diff;

    // A set top bit in p means 2P already exceeds any N-bit divisor.
    always_comb begin
        w_pt   = {p[N-1:0], din};
        w_diff = w_pt - {1'b0, bq};
        qbit   = p[N] | (w_pt >= {1'b0, bq});
        p_next = qbit ? w_diff : w_pt;
    end

endmodule
`default_nettype wire

// File: rtl/shift_and_subtract_binary_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_and_subtract_binary_divider : restoring unsigned divider       |
// | Revision                          : 1.0                              |
// +----------------------------------------------------------------------+
module shift_and_subtract_binary_divider
    import arith_pkg::*;
#(
    parameter int M = DIV_M,
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [N-1:0] B,
    output logic [M-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         dbz
);

    localparam int            c_CW   = clog2(M + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(M - 1);

    div_state_t      r_state;
    div_state_t      w_state_next;
    logic [M-1:0]    r_d;
    logic [N-1:0]    r_bq;
    logic [N:0]      r_p;
    logic [c_CW-1:0] r_cnt;
    logic [M-1:0]    r_q;
    logic [N-1:0]    r_r;
    logic            r_dbz;

    logic [N:0]      w_p_next;
    logic            w_qbit;
    logic [M-1:0]    w_d_next;
    logic            w_accept;
    logic            w_busy;
    logic            w_done;

    div_restore_step #(.N(N)) u_step (
        .p      (r_p),
        .din    (r_d[M-1]),
        .bq     (r_bq),
        .p_next (w_p_next),
        .qbit   (w_qbit)
    );

    if (M > 1) begin : g_dshift_wide
        assign w_d_next = {r_d[M-2:0], w_qbit};
    end else begin : g_dshift_narrow
        assign w_d_next = w_qbit;
    end

    assign w_accept = start && (r_state != RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = (B == '0) ? DONE : RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == c_LAST) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == RUN);
        w_done = (r_state == DONE);
    end

    // Results only change on entry to DONE so they stay readable across a new divide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d   <= '0;
            r_bq  <= '0;
            r_p   <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_d   <= A;
            r_bq  <= B;
            r_p   <= '0;
            r_cnt <= '0;
            if (B == '0) begin
                r_q   <= '1;
                r_r   <= A[N-1:0];
                r_dbz <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_p   <= w_p_next;
            r_d   <= w_d_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
                r_q   <= w_d_next;
                r_r   <= w_p_next[N-1:0];
                r_dbz <= 1'b0;
            end
        end
    end

    assign Q    = r_q;
    assign R    = r_r;
    assign dbz  = r_dbz;
    assign busy = w_busy;
    assign done = w_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_and_subtract_binary_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_and_subtract_binary_divider : directed + random bench       |
// | Revision                             : 1.0                           |
// +----------------------------------------------------------------------+
module tb_shift_and_subtract_binary_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Q;
    logic [7:0] R;
    logic       busy;
    logic       done;
    logic       dbz;

    int checks;
    int passed;

    shift_and_subtract_binary_divider #(.M(8), .N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Waits for done, counting negedges; a bound of 40 keeps a stuck DUT from hanging.
    task automatic wait_done(output int lat, output int busyc);
        lat   = 0;
        busyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) busyc++;
        end while (!done && lat < 40);
    endtask

    task automatic run_div(input string tag, input int a, input int b,
                           input int eq, input int er, input int edbz,
                           input int elat, input int ebusy);
        int lat;
        int busyc;
        @(negedge clk);
        A     = 8'(a);
        B     = 8'(b);
        start = 1'b1;
        wait_done(lat, busyc);
        chk({tag, "_lat"},  lat,   elat);
        chk({tag, "_busy"}, busyc, ebusy);
        chk({tag, "_q"},    int'(Q),   eq);
        chk({tag, "_r"},    int'(R),   er);
        chk({tag, "_dbz"},  int'(dbz), edbz);
    endtask

    initial begin
        int lat;
        int busyc;
        int ndone;
        int a;
        int b;
        checks = 0;
        passed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        A      = '0;
        B      = '0;

        repeat (2) @(negedge clk);
        chk("rst_q",    int'(Q),    0);
        chk("rst_r",    int'(R),    0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dbz",  int'(dbz),  0);
        rst = 1'b0;

        run_div("d100_7", 100, 7, 14, 2, 0, 9, 8);
        @(negedge clk);
        chk("pulse_done", int'(done), 0);
        chk("hold_q",     int'(Q),    14);

        run_div("d255_1", 255, 1, 255, 0, 0, 9, 8);
        run_div("d5_9",   5,   9, 0,   5, 0, 9, 8);
        run_div("d200_200", 200, 200, 1, 0, 0, 9, 8);
        run_div("dbz77", 77, 0, 255, 77, 1, 1, 0);
        @(negedge clk);
        chk("dbz_after_busy", int'(busy), 0);
        chk("dbz_after_done", int'(done), 0);

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        A = 8'd100; B = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'd9; B = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busyc);
        chk("ign_lat", lat, 5);
        chk("ign_q",   int'(Q),   14);
        chk("ign_r",   int'(R),   2);
        chk("ign_dbz", int'(dbz), 0);

        // Asynchronous reset mid-divide.
        @(negedge clk);
        A = 8'd200; B = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_q",    int'(Q),    0);
        chk("arst_r",    int'(R),    0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst_nodone", ndone, 0);
        run_div("d50_6", 50, 6, 8, 2, 0, 9, 8);

        // Back-to-back: new start held during the done cycle.
        @(negedge clk);
        A = 8'd100; B = 8'd7; start = 1'b1;
        wait_done(lat, busyc);
        chk("b2b1_q", int'(Q), 14);
        A = 8'd60; B = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_hold_q", int'(Q), 14);
        chk("b2b_hold_r", int'(R), 2);
        wait_done(lat, busyc);
        chk("b2b2_lat", lat, 8);
        chk("b2b2_q",   int'(Q), 7);
        chk("b2b2_r",   int'(R), 4);

        for (int i = 0; i < 2000; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            @(negedge clk);
            A = 8'(a); B = 8'(b); start = 1'b1;
            wait_done(lat, busyc);
            chk("rand_inv", int'(Q) * b + int'(R), a);
            chk("rand_rlt", int'(int'(R) < b), 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
